// File: rtl/key_scan_ctrl.sv
// Row-multiplexed key scanner: walks sel over rows 0..2, debounces whole-scan
// frames and reports accepted keys. Define KEY_REPEAT_EN for auto-repeat while held.
module key_scan_ctrl #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 60
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] sel,
  input  logic       press,
  input  logic [3:0] scan_code,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int         DIV_W   = $clog2(SCAN_DIV);
  localparam logic [3:0] NO_KEY  = 4'hF;
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       frame_code_q, frame_code_d;
  logic             hit_q, hit_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  logic       sample;
  logic       frame_end;
  logic [3:0] frame_val;

  assign sample    = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample && (sel_q == 3'd2);
  // The row-2 sample belongs to the closing frame, so it is folded in directly.
  assign frame_val = hit_q ? frame_code_q : (press ? scan_code : NO_KEY);

  always_comb begin
    div_cnt_d    = sample ? '0 : div_cnt_q + DIV_W'(1);
    sel_d        = sel_q;
    hit_d        = hit_q;
    frame_code_d = frame_code_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d        = rep_q;
`endif

    if (sample) begin
      sel_d = (sel_q == 3'd2) ? 3'd0 : sel_q + 3'd1;
      if (frame_end) begin
        hit_d        = 1'b0;
        frame_code_d = NO_KEY;
      end else if (press && !hit_q) begin
        hit_d        = 1'b1;
        frame_code_d = scan_code;
      end
    end

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_val != NO_KEY) begin
            cand_d  = frame_val;
            cnt_d   = 4'd1;
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_val == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_LAST) begin
              key_valid_d = 1'b1;
              key_code_d  = cand_q;
              state_d     = ST_HELD;
`ifdef KEY_REPEAT_EN
              rep_d       = '0;
`endif
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (frame_val == cand_q) begin
`ifdef KEY_REPEAT_EN
            if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
`endif
          end else begin
            cnt_d   = 4'd1;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (frame_val == cand_q) begin
            state_d = ST_HELD;
`ifdef KEY_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            // Any non-matching frame, even another key, counts toward release.
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB_LAST) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      sel_q        <= 3'd0;
      cnt_q        <= 4'd0;
      cand_q       <= NO_KEY;
      frame_code_q <= NO_KEY;
      hit_q        <= 1'b0;
      key_code_q   <= NO_KEY;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      frame_code_q <= frame_code_d;
      hit_q        <= hit_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
`ifdef KEY_REPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign dbg_state = state_q;

endmodule
